// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: bus-mapped LED controller with static/PWM channels and a prescaled PWM counter.
// Blink logic (BLINK register at 0x3) exists only when LED_BLINK_EN is defined.
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif
module led_pwm_ctrl #(
  parameter int CPU_WIDTH   = 16,
  parameter int LED_NUM     = 4,
  parameter int PWM_WIDTH   = 8,
  parameter int BLINK_SHIFT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EN,
  input  logic [CPU_WIDTH-1:0] addr,
  inout  wire  [CPU_WIDTH-1:0] data,
  input  logic                 ctrl,
  output logic [LED_NUM-1:0]   led
);
  logic                 wr, rd, pre_wr, tick;
  logic [3:0]           a;
  logic                 unused_addr;
  logic [LED_NUM-1:0]   out_q, out_d, mode_q, mode_d, led_d;
  logic [CPU_WIDTH-1:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d, rd_data;
  logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_WIDTH-1:0] duty_q [LED_NUM];
  logic [PWM_WIDTH-1:0] duty_d [LED_NUM];
`ifdef LED_BLINK_EN
  logic [LED_NUM-1:0]     blink_q, blink_d;
  logic [BLINK_SHIFT-1:0] blink_cnt_q, blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d, period_end;
`else
  localparam int unused_blink_shift = BLINK_SHIFT;
`endif
  assign a           = addr[3:0];
  assign unused_addr = ^addr[CPU_WIDTH-1:4];
  assign wr          = EN && ctrl == `IO_CTRL_WRITE;
  assign rd          = EN && ctrl == `IO_CTRL_READ;
  assign pre_wr      = wr && a == 4'h2;
  // a PRESCALE write restarts the divider and suppresses that cycle's tick
  assign tick        = !pre_wr && pre_cnt_q == prescale_q;
  assign data        = rd ? rd_data : 'z;
  always_comb begin
    out_d      = wr && a == 4'h0 ? data[LED_NUM-1:0] : out_q;
    mode_d     = wr && a == 4'h1 ? data[LED_NUM-1:0] : mode_q;
    prescale_d = pre_wr ? data : prescale_q;
    pre_cnt_d  = pre_wr || tick ? '0 : pre_cnt_q + CPU_WIDTH'(1);
    pwm_cnt_d  = tick ? pwm_cnt_q + PWM_WIDTH'(1) : pwm_cnt_q;
    rd_data    = a == 4'h0 ? CPU_WIDTH'(out_q) : a == 4'h1 ? CPU_WIDTH'(mode_q) :
                 a == 4'h2 ? prescale_q : '0;
`ifdef LED_BLINK_EN
    period_end    = tick && &pwm_cnt_q;
    blink_d       = wr && a == 4'h3 ? data[LED_NUM-1:0] : blink_q;
    blink_cnt_d   = period_end ? blink_cnt_q + BLINK_SHIFT'(1) : blink_cnt_q;
    blink_phase_d = blink_phase_q ^ (period_end && &blink_cnt_q);
    if (a == 4'h3) rd_data = CPU_WIDTH'(blink_q);
`endif
    for (int i = 0; i < LED_NUM; i++) begin
      duty_d[i] = wr && a == 4'(8 + i) ? data[PWM_WIDTH-1:0] : duty_q[i];
      if (a == 4'(8 + i)) rd_data = CPU_WIDTH'(duty_q[i]);
      led_d[i]  = mode_q[i] ? pwm_cnt_q < duty_q[i] : out_q[i];
`ifdef LED_BLINK_EN
      led_d[i]  = led_d[i] & !(blink_q[i] & blink_phase_q);
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      mode_q     <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      led        <= '0;
      for (int i = 0; i < LED_NUM; i++) duty_q[i] <= '0;
`ifdef LED_BLINK_EN
      blink_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
`endif
    end else begin
      out_q      <= out_d;
      mode_q     <= mode_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led        <= led_d;
      for (int i = 0; i < LED_NUM; i++) duty_q[i] <= duty_d[i];
`ifdef LED_BLINK_EN
      blink_q       <= blink_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb_led_pwm_ctrl: register-map vector table plus PWM, prescaler, blink and reset sequences.
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif
module tb_led_pwm_ctrl;
`ifdef LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, EN = 1'b0, ctrl = `IO_CTRL_READ, drv_en = 1'b0;
  logic [15:0] addr = '0, drv_val = '0;
  wire  [15:0] data;
  logic [3:0]  led;
  int          checks = 0, errors = 0;
  typedef struct { string name; logic [15:0] exp; } sb_t;
  typedef struct { bit is_wr; logic [15:0] a; logic [15:0] d; string name; } vec_t;
  sb_t  sb[$];
  vec_t vecs[$];
  assign data = drv_en ? drv_val : 'z;
  always #5 clk = ~clk;
  led_pwm_ctrl #(.CPU_WIDTH(16), .LED_NUM(4), .PWM_WIDTH(8), .BLINK_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .EN(EN), .addr(addr), .data(data), .ctrl(ctrl), .led(led)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // all tasks start and end right after a falling edge
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    EN = 1'b1; ctrl = `IO_CTRL_WRITE; addr = a; drv_en = 1'b1; drv_val = d;
    @(negedge clk);
    EN = 1'b0; drv_en = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    sb_t e;
    EN = 1'b1; ctrl = `IO_CTRL_READ; addr = a; drv_en = 1'b0;
    sb.push_back('{name, exp});
    #1;
    e = sb.pop_front();
    chk(e.name, {16'h0, data}, {16'h0, e.exp});
    @(negedge clk);
    EN = 1'b0;
  endtask
  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (led[0]) c++;
    end
  endtask
  task automatic wait_change(input int limit, output int cyc);
    logic v;
    v = led[0];
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (led[0] !== v) return;
    end
    cyc = -1;
  endtask
  task automatic wait_level(input logic v, input int limit, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (led[0] !== v) begin
      if (n++ >= limit) begin ok = 1'b0; return; end
      @(negedge clk);
    end
  endtask
  task automatic high_run(output int c);
    c = 0;
    while (led[0] === 1'b1 && c < 2000) begin
      c++;
      @(negedge clk);
    end
  endtask
  initial begin
    int c, c1, c2;
    bit ok;
    vecs.push_back('{1'b1, 16'h0005, 16'hFFFF, "wr_undec5"});
    vecs.push_back('{1'b0, 16'h0000, 16'h000A, "ign_out"});
    vecs.push_back('{1'b0, 16'h0001, 16'h0000, "ign_mode"});
    vecs.push_back('{1'b0, 16'h0002, 16'h0000, "ign_prescale"});
    vecs.push_back('{1'b0, 16'h0005, 16'h0000, "rd_undec5"});
    vecs.push_back('{1'b0, 16'h000C, 16'h0000, "rd_duty_oor"});
    vecs.push_back('{1'b1, 16'h000C, 16'h00FF, "wr_duty_oor"});
    vecs.push_back('{1'b0, 16'h000C, 16'h0000, "rd_duty_oor2"});
    vecs.push_back('{1'b1, 16'h0008, 16'h1234, "wr_duty0"});
    vecs.push_back('{1'b0, 16'h0008, 16'h0034, "rd_duty0"});
    vecs.push_back('{1'b1, 16'h000B, 16'h00C3, "wr_duty3"});
    vecs.push_back('{1'b0, 16'h000B, 16'h00C3, "rd_duty3"});
    vecs.push_back('{1'b1, 16'h0002, 16'hABCD, "wr_prescale"});
    vecs.push_back('{1'b0, 16'h0002, 16'hABCD, "rd_prescale"});
    vecs.push_back('{1'b1, 16'h0002, 16'h0000, "wr_prescale0"});
    vecs.push_back('{1'b1, 16'h0003, 16'h0001, "wr_blink"});
    vecs.push_back('{1'b0, 16'h0003, BLINK ? 16'h0001 : 16'h0000, "rd_blink"});
    vecs.push_back('{1'b1, 16'h0003, 16'h0000, "wr_blink0"});
    vecs.push_back('{1'b1, 16'h0000, 16'h003A, "wr_out_wide"});
    vecs.push_back('{1'b0, 16'h0000, 16'h000A, "rd_out_trunc"});
    vecs.push_back('{1'b0, 16'h0010, 16'h000A, "rd_out_alias"});
    @(negedge clk); chk("reset_led_c1", {28'h0, led}, 32'h0);
    @(negedge clk); chk("reset_led_c2", {28'h0, led}, 32'h0);
    rst = 1'b0;
    wr(16'h0, 16'h000A);
    chk("out_latency", {28'h0, led}, 32'h0);
    @(negedge clk); chk("out_led", {28'h0, led}, 32'hA);
    rd(16'h0, 16'h000A, "rd_out");
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) wr(vecs[i].a, vecs[i].d);
      else rd(vecs[i].a, vecs[i].d, vecs[i].name);
    end
    // with EN low the bench alone must own the bus
    EN = 1'b0; ctrl = `IO_CTRL_READ; addr = 16'h0; drv_en = 1'b1; drv_val = 16'h5A50;
    #1 chk("en0_release", {16'h0, data}, 32'h5A50);
    drv_en = 1'b0;
    @(negedge clk);
    wr(16'h1, 16'h1);
    wr(16'h8, 16'h40);
    count_high(256, c); chk("pwm_duty40", c, 64);
    wr(16'h8, 16'h0);
    count_high(300, c); chk("pwm_duty0", c, 0);
    wr(16'h8, 16'hFF);
    count_high(256, c); chk("pwm_dutyff", c, 255);
    wr(16'h8, 16'h80);
    wr(16'h2, 16'h3);
    count_high(1024, c); chk("ps3_duty80", c, 512);
    wait_change(3000, c);
    wait_change(3000, c1);
    wait_change(3000, c2);
    chk("ps3_half", c1, 512);
    chk("ps3_period", c1 + c2, 1024);
    wr(16'h8, 16'h1);
    wait_level(1'b0, 3000, ok);
    wait_level(1'b1, 3000, ok);
    chk("ps3_sync", {31'h0, ok}, 32'h1);
    high_run(c); chk("ps3_tick_width", c, 4);
    wait_level(1'b1, 3000, ok);
    wr(16'h2, 16'h3);
    high_run(c); chk("ps_rewrite_restart", c + 1, 6);
    wr(16'h2, 16'h0);
    wr(16'h1, 16'h0);
    wr(16'h0, 16'h1);
    wr(16'h3, 16'h1);
    if (BLINK) begin
      wait_change(2000, c);
      wait_change(2000, c);
      wait_change(2000, c1);
      wait_change(2000, c2);
      chk("blink_toggle1", c1, 512);
      chk("blink_toggle2", c2, 512);
    end else begin
      count_high(1100, c); chk("no_blink_steady", c, 1100);
    end
    wr(16'h3, 16'h0);
    wr(16'h8, 16'h80); wr(16'h9, 16'h40); wr(16'hA, 16'h20); wr(16'hB, 16'h10);
    wr(16'h2, 16'h1);
    wr(16'h1, 16'hF);
    repeat (37) @(negedge clk);
    rst = 1'b1;
    EN = 1'b1; ctrl = `IO_CTRL_WRITE; addr = 16'h0; drv_en = 1'b1; drv_val = 16'hF;
    @(negedge clk);
    chk("rst_mid_led", {28'h0, led}, 32'h0);
    rst = 1'b0; EN = 1'b0; drv_en = 1'b0;
    @(negedge clk);
    chk("rst_priority_led", {28'h0, led}, 32'h0);
    rd(16'h0, 16'h0, "rst_out");
    rd(16'h1, 16'h0, "rst_mode");
    rd(16'h2, 16'h0, "rst_prescale");
    rd(16'h3, 16'h0, "rst_blink");
    for (int i = 0; i < 4; i++) rd(16'(8 + i), 16'h0, $sformatf("rst_duty%0d", i));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
